// File: rtl/rv32ima_pkg.sv
// Shared types for the rv32ima memory subsystem: the RAM arbiter FSM state
// encoding and the grant encoding used to name the winning requester.
package rv32ima_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one synchronous RAM between instruction fetch and
// data load/store. Each access takes two cycles: the address is presented in
// IDLE, the RAM answers during the following BUSY cycle, where the grantee's
// ready pulses.
// Optional feature: define RAM_ARB_RR_EN to replace fixed data priority with
// alternating arbitration on contention (first contention after reset goes
// to fetch).
module ram_arbiter
  import rv32ima_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_load
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  grant_t     w_grant;
  logic       w_any_req;

  assign w_any_req = i_req | d_req;

`ifdef RAM_ARB_RR_EN
  grant_t r_last;

  // Grant selection: on contention, favour whoever did not win last time.
  always_comb begin
    w_grant = GRANT_D;
    if (i_req && d_req) begin
      w_grant = (r_last == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_req) begin
      w_grant = GRANT_D;
    end else begin
      w_grant = GRANT_I;
    end
  end

  // Last-grant history: reset to DATA so the first contention goes to fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= GRANT_D;
    end else if ((r_state == IDLE) && w_any_req) begin
      r_last <= w_grant;
    end
  end
`else
  // Fixed priority: data always beats fetch.
  assign w_grant = d_req ? GRANT_D : GRANT_I;
`endif

  // State register; reset drops any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: grant from IDLE, every BUSY state lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = (w_grant == GRANT_D) ? BUSY_D : BUSY_I;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_I:  w_state_nxt = IDLE;
      BUSY_D:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: RAM command in IDLE (suppressed while reset is held so no write
  // slips through), ready pulse in the BUSY state of the grantee.
  always_comb begin
    ram_addr  = '0;
    ram_store = '0;
    ram_wen   = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req && !rst) begin
          if (w_grant == GRANT_D) begin
            ram_addr  = d_addr;
            ram_store = d_wdata;
            ram_wen   = d_wen;
          end else begin
            ram_addr  = i_addr;
          end
        end else begin
          ram_addr = '0;
        end
      end
      BUSY_I:  i_ready = 1'b1;
      BUSY_D:  d_ready = 1'b1;
      default: begin
        i_ready = 1'b0;
        d_ready = 1'b0;
      end
    endcase
  end

  assign i_rdata = ram_load;
  assign d_rdata = ram_load;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random
// traffic from two requesters, checked against a transaction-level model
// (one access in service at a time, each served in two cycles) and a shadow
// copy of the RAM contents.
module tb_ram_arbiter;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
`ifdef RAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req, d_wen;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              i_ready, d_ready, ram_wen;
  logic [DATA_W-1:0] i_rdata, d_rdata, ram_store, ram_load;
  logic [ADDR_W-1:0] ram_addr;

  // RAM model with a bench-side preload port
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] exp_mem [0:31];

  int n_checks = 0;
  int n_errors = 0;

  // Transaction model state
  bit m_busy, m_own_d, m_last_d, g_d;
  bit exp_i, exp_d;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_store(ram_store), .ram_wen(ram_wen),
    .ram_load(ram_load)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: registers address/data/wen, read data valid next cycle
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_wen) mem[ram_addr] <= ram_store;
    ram_load <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    tick();
    pre_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    tick(); tick();
    check_eq("rst_i_ready", i_ready, 1'b0);
    check_eq("rst_d_ready", d_ready, 1'b0);
    check_eq("rst_ram_wen", ram_wen, 1'b0);
    check_eq("rst_ram_addr", ram_addr, '0);
    preload(14'h010, 32'h0000_0013);
    rst = 1'b0;
    tick();

    // Contention right after reset: fixed -> D then I; alternating -> I then D
    i_req = 1'b1; i_addr = 14'h010;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 14'h010;
    tick();
    check_eq("cont_first_i", i_ready, RR ? 1'b1 : 1'b0);
    check_eq("cont_first_d", d_ready, RR ? 1'b0 : 1'b1);
    if (RR) i_req = 1'b0; else d_req = 1'b0;
    tick();
    check_eq("cont_gap_i", i_ready, 1'b0);
    check_eq("cont_gap_d", d_ready, 1'b0);
    tick();
    check_eq("cont_second_i", i_ready, RR ? 1'b0 : 1'b1);
    check_eq("cont_second_d", d_ready, RR ? 1'b1 : 1'b0);
    check_eq("cont_second_data", RR ? d_rdata : i_rdata, 32'h0000_0013);
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Plain fetch
    i_req = 1'b1; i_addr = 14'h010;
    tick();
    check_eq("fetch_ready", i_ready, 1'b1);
    check_eq("fetch_data", i_rdata, 32'h0000_0013);
    check_eq("fetch_d_ready", d_ready, 1'b0);
    i_req = 1'b0;
    tick();
    check_eq("fetch_pulse_end", i_ready, 1'b0);

    // Store then load
    d_req = 1'b1; d_wen = 1'b1; d_addr = 14'h020; d_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("store_wen_idle", ram_wen, 1'b1);
    check_eq("store_addr", ram_addr, 14'h020);
    tick();
    check_eq("store_ready", d_ready, 1'b1);
    check_eq("store_wen_busy", ram_wen, 1'b0);
    d_req = 1'b0; d_wen = 1'b0;
    tick();
    d_req = 1'b1; d_addr = 14'h020;
    tick();
    check_eq("load_ready", d_ready, 1'b1);
    check_eq("load_data", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    tick();

    // Reset while a store is in BUSY_D
    d_req = 1'b1; d_wen = 1'b1; d_addr = 14'h040; d_wdata = 32'h1234_5678;
    tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_d_ready", d_ready, 1'b0);
    check_eq("midrst_ram_wen", ram_wen, 1'b0);
    tick();
    check_eq("midrst_held_d_ready", d_ready, 1'b0);
    rst = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    i_req = 1'b1; i_addr = 14'h010;
    #1;
    check_eq("postrst_idle", i_ready, 1'b0);
    tick();
    check_eq("postrst_fetch_ready", i_ready, 1'b1);
    check_eq("postrst_fetch_data", i_rdata, 32'h0000_0013);
    i_req = 1'b0;
    tick();

    // Random traffic over a small address window
    for (int a = 0; a < 32; a++) begin
      exp_mem[a] = $urandom;
      preload(a[ADDR_W-1:0], exp_mem[a]);
    end
    m_busy = 1'b0; m_own_d = 1'b0; m_last_d = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      exp_i = m_busy && !m_own_d;
      exp_d = m_busy && m_own_d;
      check_eq("rnd_i_ready", i_ready, exp_i);
      check_eq("rnd_d_ready", d_ready, exp_d);
      if (exp_i) begin
        check_eq("rnd_i_rdata", i_rdata, exp_mem[i_addr[4:0]]);
        i_req = 1'b0;
      end
      if (exp_d) begin
        if (d_wen) exp_mem[d_addr[4:0]] = d_wdata;
        else check_eq("rnd_d_rdata", d_rdata, exp_mem[d_addr[4:0]]);
        d_req = 1'b0;
      end
      if (!i_req && ($urandom_range(0, 1) == 1)) begin
        i_req = 1'b1; i_addr = ADDR_W'($urandom_range(0, 31));
      end
      if (!d_req && ($urandom_range(0, 1) == 1)) begin
        d_req = 1'b1; d_addr = ADDR_W'($urandom_range(0, 31));
        d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      #1;
      if (m_busy) begin
        check_eq("rnd_wen_busy", ram_wen, 1'b0);
        m_busy = 1'b0;
      end else if (i_req || d_req) begin
        if (i_req && d_req) g_d = RR ? !m_last_d : 1'b1;
        else g_d = d_req;
        check_eq("rnd_ram_addr", ram_addr, g_d ? d_addr : i_addr);
        check_eq("rnd_ram_wen", ram_wen, g_d && d_wen);
        if (g_d) check_eq("rnd_ram_store", ram_store, d_wdata);
        m_last_d = g_d; m_own_d = g_d; m_busy = 1'b1;
      end else begin
        check_eq("rnd_idle_addr", ram_addr, '0);
        check_eq("rnd_idle_wen", ram_wen, 1'b0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
